// File: rtl/rotate_left_seq_pkg.sv
// Shared constants for the sequential rotate-left unit: FSM state encodings and default sizes.
package rotate_left_seq_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
endpackage

// File: rtl/rotate_left_seq_if.sv
// Request/result bundle between the control unit (master) and the rotate unit (slave).
interface rotate_left_seq_if
  import rotate_left_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) ();
  logic             start;
  logic [WIDTH-1:0] indata;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] outdata;
  logic             busy;
  logic             done;

  modport master (output start, indata, amount, input outdata, busy, done);
  modport slave  (input start, indata, amount, output outdata, busy, done);
endinterface

// File: rtl/rotate_left_seq_rotl1.sv
// Combinational single-bit rotate left: MSB wraps into LSB.
module rotate_left_seq_rotl1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = {x[WIDTH-2:0], x[WIDTH-1]};
endmodule

// File: rtl/rotate_left_seq.sv
// Multi-cycle rotate-left: latches operand/amount on start, rotates one bit per clock,
// then pulses done for one cycle. busy covers RUN and DONE; start is only sampled in IDLE.
module rotate_left_seq
  import rotate_left_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  rotate_left_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_rot;
  logic [CNT_W-1:0] count;

  rotate_left_seq_rotl1 #(.WIDTH(WIDTH)) u_rotl1 (
    .x (data_q),
    .y (data_rot)
  );

  // Amount is taken modulo WIDTH, so only the low CNT_W bits matter.
  generate
    if (AMT_W > CNT_W) begin : g_amt_hi
      logic unused_amt_hi;
      assign unused_amt_hi = ^bus.amount[AMT_W-1:CNT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            data_q <= bus.indata;
            count  <= bus.amount[CNT_W-1:0];
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (count != '0) begin
            data_q <= data_rot;
            count  <= count - CNT_W'(1);
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.outdata = data_q;
  assign bus.busy    = (state == ST_RUN) || (state == ST_DONE);
  assign bus.done    = (state == ST_DONE);
endmodule

// File: tb/tb_rotate_left_seq.sv
// Scoreboarded random/directed bench for rotate_left_seq against an arithmetic rotate model.
module tb_rotate_left_seq;
  import rotate_left_seq_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotate_left_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  rotate_left_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x, input int amt);
    int n;
    int v;
    n = amt % W;
    v = int'(x);
    if (n != 0) v = ((v << n) | (v >> (W - n))) & ((1 << W) - 1);
    return W'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("outdata", 32'(bus.outdata), 32'(mon_e.data));
        chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [W-1:0] d, input int a);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.indata = d;
    bus.amount = AW'(a);
    sb_q.push_back('{data: ref_rotl(d, a), lat: (a % W) + 1, t0: cyc + 1});
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.indata = W'($urandom);
    bus.amount = AW'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0a;
    bus.start  = 1'b0;
    bus.indata = '0;
    bus.amount = '0;

    #12;
    chk("rst_outdata", 32'(bus.outdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-RUN aborts the operation; no done may follow.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.indata = 8'hFF;
    bus.amount = 4'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_outdata", 32'(bus.outdata), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Directed cases.
    issue(8'b1000_0001, 1);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    issue(8'hA5, 0);
    wait_done();
    issue(8'hA5, 8);
    wait_done();
    issue(8'hA5, 11);
    wait_done();
    issue(8'h01, 7);
    wait_done();

    // Start pulses during RUN and DONE are ignored.
    issue(8'h3C, 5);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.indata = 8'h00;
    bus.amount = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    bus.start  = 1'b1;
    bus.indata = 8'h00;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Start held high: second op accepted in the first IDLE cycle after done.
    bus.start  = 1'b1;
    bus.indata = 8'h81;
    bus.amount = 4'd2;
    t0a = cyc + 1;
    sb_q.push_back('{data: ref_rotl(8'h81, 2), lat: 3, t0: t0a});
    sb_q.push_back('{data: ref_rotl(8'h3C, 5), lat: 6, t0: t0a + 2 + 3});
    @(posedge clk);
    #1;
    bus.indata = 8'h3C;
    bus.amount = 4'd5;
    wait_done();
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();

    // Random operations with occasional gaps.
    for (int k = 0; k < 1000; k++) begin
      issue(W'($urandom), int'($urandom_range(0, 15)));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
